// File: rtl/cdc_fifo_packer.sv
// Packs narrow producer beats into wide words for a CDC FIFO.
// Supports partial-word flush with a per-lane valid mask.
module cdc_fifo_packer #(
  parameter int INPUT_BITWIDTH = 8,
  parameter int RATIO          = 4
) (
  input  logic                            clk,
  input  logic                            sync_rst,
  input  logic                            InputREQ,
  output logic                            InputACK,
  input  logic [INPUT_BITWIDTH-1:0]       InputData,
  input  logic                            FlushREQ,
  output logic                            FlushACK,
  output logic                            OutputREQ,
  input  logic                            OutputACK,
  output logic [INPUT_BITWIDTH*RATIO-1:0] OutputData,
  output logic [RATIO-1:0]                OutputMask
);

  localparam int OUTPUT_BITWIDTH = INPUT_BITWIDTH * RATIO;
  localparam int CW = $clog2(RATIO);

  logic [OUTPUT_BITWIDTH-1:0] acc_q, acc_d, acc_wr;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       oreq_q, oreq_d;
  logic [OUTPUT_BITWIDTH-1:0] odata_q, odata_d;
  logic [RATIO-1:0]           omask_q, omask_d;

  logic          slot_free;
  logic          last;
  logic          in_fire;
  logic          fl_fire;
  logic          emit;
  logic [CW:0]   filled;

  // Handshake qualification; the holding slot may reload as it drains.
  always_comb begin
    slot_free = !oreq_q || OutputACK;
    last      = (cnt_q == CW'(RATIO - 1));
    InputACK  = !sync_rst && (!last || slot_free);
    FlushACK  = !sync_rst && slot_free;
    OutputREQ = oreq_q && !sync_rst;
    in_fire   = InputREQ && InputACK;
    fl_fire   = FlushREQ && FlushACK;
    filled    = {1'b0, cnt_q} + (CW + 1)'(in_fire);
    emit      = (in_fire && last) || (fl_fire && (filled != '0));
  end

  // Accumulator with the current beat merged into its lane.
  always_comb begin
    acc_wr = acc_q;
    for (int i = 0; i < RATIO; i++) begin
      if (in_fire && (cnt_q == CW'(i))) begin
        acc_wr[i*INPUT_BITWIDTH +: INPUT_BITWIDTH] = InputData;
      end
    end
  end

  // Next-state: complete or flushed words move to the holding register.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    oreq_d  = oreq_q && !OutputACK;
    odata_d = odata_q;
    omask_d = omask_q;
    if (emit) begin
      oreq_d  = 1'b1;
      odata_d = acc_wr;
      for (int i = 0; i < RATIO; i++) begin
        omask_d[i] = ((CW + 1)'(i) < filled);
      end
      acc_d = '0;
      cnt_d = '0;
    end else if (in_fire) begin
      acc_d = acc_wr;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset discarding all data.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      oreq_q  <= 1'b0;
      odata_q <= '0;
      omask_q <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      oreq_q  <= oreq_d;
      odata_q <= odata_d;
      omask_q <= omask_d;
    end
  end

  assign OutputData = odata_q;
  assign OutputMask = omask_q;

endmodule

// File: tb/tb_cdc_fifo_packer.sv
// Bench for cdc_fifo_packer: directed scenarios plus random traffic
// checked against a queue-based word model.
module tb_cdc_fifo_packer;

  localparam int IW = 8;
  localparam int R  = 4;
  localparam int OW = IW * R;

  logic          clk = 1'b0;
  logic          sync_rst;
  logic          InputREQ;
  logic          InputACK;
  logic [IW-1:0] InputData;
  logic          FlushREQ;
  logic          FlushACK;
  logic          OutputREQ;
  logic          OutputACK;
  logic [OW-1:0] OutputData;
  logic [R-1:0]  OutputMask;

  cdc_fifo_packer #(.INPUT_BITWIDTH(IW), .RATIO(R)) dut (
    .clk(clk),
    .sync_rst(sync_rst),
    .InputREQ(InputREQ),
    .InputACK(InputACK),
    .InputData(InputData),
    .FlushREQ(FlushREQ),
    .FlushACK(FlushACK),
    .OutputREQ(OutputREQ),
    .OutputACK(OutputACK),
    .OutputData(OutputData),
    .OutputMask(OutputMask)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [IW-1:0] beats[$];
  bit            pend;
  logic [OW-1:0] pdata;
  logic [R-1:0]  pmask;
  bit            accepted;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(bit rst, bit r, logic [IW-1:0] d, bit f, bit a);
    bit slot;
    bit iack;
    bit fl;
    @(negedge clk);
    sync_rst  = rst;
    InputREQ  = r;
    InputData = d;
    FlushREQ  = f;
    OutputACK = a;
    #1;
    accepted = 1'b0;
    if (rst) begin
      chk("rst_iack", 32'(InputACK), 32'd0);
      chk("rst_fack", 32'(FlushACK), 32'd0);
      chk("rst_oreq", 32'(OutputREQ), 32'd0);
      beats.delete();
      pend  = 1'b0;
      pdata = '0;
      pmask = '0;
    end else begin
      slot = !pend || a;
      iack = (beats.size() < R - 1) || slot;
      chk("iack", 32'(InputACK), 32'(iack));
      chk("fack", 32'(FlushACK), 32'(slot));
      chk("oreq", 32'(OutputREQ), 32'(pend));
      chk("odata", OutputData, pdata);
      chk("omask", 32'(OutputMask), 32'(pmask));
      accepted = r && iack;
      fl = f && slot;
      if (accepted) beats.push_back(d);
      if (pend && a) pend = 1'b0;
      if (beats.size() == R || (fl && beats.size() > 0)) begin
        pdata = '0;
        foreach (beats[i]) pdata = pdata | (OW'(beats[i]) << (IW * i));
        pmask = R'((1 << beats.size()) - 1);
        pend  = 1'b1;
        beats.delete();
      end
    end
  endtask

  task automatic peek(string tag, bit req, logic [OW-1:0] data, logic [R-1:0] mask);
    @(posedge clk);
    #1;
    chk({tag, "_req"}, 32'(OutputREQ), 32'(req));
    chk({tag, "_data"}, OutputData, data);
    chk({tag, "_mask"}, 32'(OutputMask), 32'(mask));
  endtask

  initial begin
    logic [IW-1:0] bq[$];
    int guard;
    sync_rst = 1'b1;
    InputREQ = 1'b0;
    InputData = '0;
    FlushREQ = 1'b0;
    OutputACK = 1'b0;

    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 1, 8'h99, 1, 1);
    peek("post_rst", 0, 32'h0, 4'h0);

    cyc(0, 1, 8'h11, 0, 1);
    cyc(0, 1, 8'h22, 0, 1);
    cyc(0, 1, 8'h33, 0, 1);
    cyc(0, 1, 8'h44, 0, 1);
    peek("full", 1, 32'h44332211, 4'hf);
    cyc(0, 0, 8'h00, 0, 1);

    for (int k = 0; k < 4; k++) cyc(0, 1, 8'(8'hA1 + k), 0, 0);
    for (int k = 0; k < 8; k++) bq.push_back(8'(8'hB1 + k));
    for (int k = 0; k < 7; k++) begin
      cyc(0, 1, bq[0], 0, 0);
      if (accepted) void'(bq.pop_front());
    end
    guard = 0;
    while (bq.size() > 0 && guard < 40) begin
      cyc(0, 1, bq[0], 0, 1);
      if (accepted) void'(bq.pop_front());
      guard++;
    end
    chk("bp_drained", 32'(bq.size()), 32'd0);
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);

    cyc(0, 1, 8'hAA, 0, 1);
    cyc(0, 1, 8'hBB, 0, 1);
    cyc(0, 0, 8'h00, 1, 1);
    peek("pflush", 1, 32'h0000BBAA, 4'h3);
    cyc(0, 0, 8'h00, 0, 1);

    cyc(0, 1, 8'h01, 0, 1);
    cyc(0, 1, 8'h02, 0, 1);
    cyc(0, 1, 8'h03, 0, 1);
    cyc(0, 1, 8'h04, 1, 1);
    peek("flfull", 1, 32'h04030201, 4'hf);
    cyc(0, 0, 8'h00, 0, 1);
    peek("flfull_one", 0, 32'h04030201, 4'hf);

    cyc(0, 0, 8'h00, 1, 1);
    peek("eflush", 0, 32'h04030201, 4'hf);

    cyc(0, 1, 8'hE1, 0, 1);
    cyc(0, 1, 8'hE2, 0, 1);
    cyc(1, 0, 8'h00, 0, 1);
    peek("midrst", 0, 32'h0, 4'h0);
    cyc(0, 1, 8'h55, 0, 1);
    cyc(0, 1, 8'h66, 0, 1);
    cyc(0, 1, 8'h77, 0, 1);
    cyc(0, 1, 8'h88, 0, 1);
    peek("rstword", 1, 32'h88776655, 4'hf);

    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 59) == 0),
          ($urandom_range(0, 3) != 0),
          8'($urandom),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
